seed_sequencer: RTL and testbench

//   On-chip driver for the gSRO datapath. Replaces the simulation-only stimulus loop.

---
 rtl/seed_sequencer.sv | 121 ++++++++++++
 tb/tb_seed_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seed_sequencer.sv
// seed_sequencer: walks seeds from a seed RAM through the gSRO datapath and reports one result record per seed
module seed_sequencer #(
    parameter int RULES        = 16,
    parameter int LOG_RULES    = 4,
    parameter int NUM_SEEDS    = 1024,
    parameter int SEED_AW      = 10,
    parameter int ROUND_NUMBER = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    output logic                 busy,
    output logic                 done,
    output logic                 seed_rd,
    output logic [SEED_AW-1:0]   seed_addr,
    input  logic [63:0]          seed_rdata,
    output logic                 dp_rst,
    output logic                 dp_ld_inhibitor,
    output logic [LOG_RULES-1:0] dp_sel_inhibitor,
    output logic                 dp_start,
    output logic [63:0]          dp_seed,
    input  logic [RULES-1:0]     dp_network_state,
    input  logic                 dp_steady_state,
    input  logic [9:0]           dp_round_number,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [SEED_AW-1:0]   res_idx,
    output logic                 res_steady,
    output logic [RULES-1:0]     res_state
);
    typedef enum logic [3:0] {IDLE, FETCH, LOAD, HOLD, RLS, LDI, GAP, STRT, ARM, RUN, REPORT, DONE} state_t;
    localparam logic [SEED_AW-1:0] LAST = SEED_AW'(NUM_SEEDS - 1);
    localparam logic [9:0] RN = 10'(ROUND_NUMBER);
    state_t state;
    logic [SEED_AW-1:0] idx;
    logic hold;
    assign dp_sel_inhibitor = '1;
    // sequencer FSM; every output is registered and set on entry to the state it belongs to
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            idx             <= '0;
            hold            <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            seed_rd         <= 1'b0;
            seed_addr       <= '0;
            dp_rst          <= 1'b0;
            dp_ld_inhibitor <= 1'b0;
            dp_start        <= 1'b0;
            dp_seed         <= '0;
            res_valid       <= 1'b0;
            res_idx         <= '0;
            res_steady      <= 1'b0;
            res_state       <= '0;
        end else begin
            seed_rd         <= 1'b0;
            dp_ld_inhibitor <= 1'b0;
            dp_start        <= 1'b0;
            done            <= 1'b0;
            case (state)
                IDLE: if (go) begin
                    state     <= FETCH;
                    busy      <= 1'b1;
                    idx       <= '0;
                    seed_rd   <= 1'b1;
                    seed_addr <= '0;
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    dp_seed <= seed_rdata;
                    dp_rst  <= 1'b0;
                    hold    <= 1'b0;
                    state   <= HOLD;
                end
                HOLD: begin
                    hold <= 1'b1;
                    if (hold) begin
                        dp_rst <= 1'b1;
                        state  <= RLS;
                    end
                end
                RLS: begin
                    dp_ld_inhibitor <= 1'b1;
                    state           <= LDI;
                end
                LDI: state <= GAP;
                GAP: begin
                    dp_start <= 1'b1;
                    state    <= STRT;
                end
                STRT: state <= ARM;
                ARM: state <= RUN;
                RUN: if (dp_round_number >= RN) begin
                    res_idx    <= idx;
                    res_steady <= dp_steady_state;
                    res_state  <= dp_network_state;
                    res_valid  <= 1'b1;
                    state      <= REPORT;
                end
                REPORT: if (res_ready) begin
                    res_valid <= 1'b0;
                    if (idx == LAST) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx       <= idx + 1'b1;
                        seed_rd   <= 1'b1;
                        seed_addr <= idx + 1'b1;
                        state     <= FETCH;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seed_sequencer.sv
// tb_seed_sequencer: directed/random bench for seed_sequencer with a behavioural datapath and seed RAM
module tb_seed_sequencer;
    localparam int N = 3;
    localparam int R = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, go = 1'b0, res_ready = 1'b0, go1 = 1'b0, res_ready1 = 1'b0;
    logic [63:0] ram [0:1023];

    logic busy, done, seed_rd, dp_rst, dp_ld, dp_start, dp_ss, res_valid, res_steady;
    logic [9:0] seed_addr, dp_rn, res_idx;
    logic [63:0] seed_rdata = '0, dp_seed;
    logic [3:0] dp_sel;
    logic [15:0] dp_ns, res_state;

    logic busy1, done1, seed_rd1, dp_rst1, dp_ld1, dp_start1, dp_ss1, res_valid1, res_steady1;
    logic [9:0] seed_addr1, dp_rn1, res_idx1;
    logic [63:0] seed_rdata1 = '0, dp_seed1;
    logic [3:0] dp_sel1;
    logic [15:0] dp_ns1, res_state1;

    seed_sequencer #(.RULES(16), .LOG_RULES(4), .NUM_SEEDS(N), .SEED_AW(10), .ROUND_NUMBER(R)) dut (
        .clk(clk), .rst(rst), .go(go), .busy(busy), .done(done),
        .seed_rd(seed_rd), .seed_addr(seed_addr), .seed_rdata(seed_rdata),
        .dp_rst(dp_rst), .dp_ld_inhibitor(dp_ld), .dp_sel_inhibitor(dp_sel), .dp_start(dp_start),
        .dp_seed(dp_seed), .dp_network_state(dp_ns), .dp_steady_state(dp_ss), .dp_round_number(dp_rn),
        .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx), .res_steady(res_steady),
        .res_state(res_state)
    );

    seed_sequencer #(.RULES(16), .LOG_RULES(4), .NUM_SEEDS(1), .SEED_AW(10), .ROUND_NUMBER(R)) dut1 (
        .clk(clk), .rst(rst), .go(go1), .busy(busy1), .done(done1),
        .seed_rd(seed_rd1), .seed_addr(seed_addr1), .seed_rdata(seed_rdata1),
        .dp_rst(dp_rst1), .dp_ld_inhibitor(dp_ld1), .dp_sel_inhibitor(dp_sel1), .dp_start(dp_start1),
        .dp_seed(dp_seed1), .dp_network_state(dp_ns1), .dp_steady_state(dp_ss1), .dp_round_number(dp_rn1),
        .res_valid(res_valid1), .res_ready(res_ready1), .res_idx(res_idx1), .res_steady(res_steady1),
        .res_state(res_state1)
    );

    // datapath model: round counter clears a cycle after start is seen, so ARM still shows a stale count
    logic start_d = 1'b0, start_d1 = 1'b0;
    logic [9:0] round = '0, round1 = '0;
    always @(posedge clk) begin
        if (seed_rd) seed_rdata <= ram[seed_addr];
        if (seed_rd1) seed_rdata1 <= ram[seed_addr1];
        start_d  <= dp_start;
        start_d1 <= dp_start1;
        round  <= start_d  ? 10'd0 : (round  == 10'd1023 ? round  : round  + 10'd1);
        round1 <= start_d1 ? 10'd0 : (round1 == 10'd1023 ? round1 : round1 + 10'd1);
    end
    assign dp_rn  = round;
    assign dp_ns  = dp_seed[15:0] ^ {6'd0, round};
    assign dp_ss  = dp_seed[16] ^ round[0];
    assign dp_rn1 = round1;
    assign dp_ns1 = dp_seed1[15:0] ^ {6'd0, round1};
    assign dp_ss1 = dp_seed1[16] ^ round1[0];

    // monitors on the falling edge
    int cyc = 0, hs_cyc = 0, done_cyc = 0, n_done = 0, n_rd = 0, multi = 0, sel_bad = 0, since = 0, low = 0;
    int hs1_cyc = 0, done1_cyc = 0, n_done1 = 0;
    logic dp_prev = 1'b0, ld_prev = 1'b0, st_prev = 1'b0, rd_prev = 1'b0, dn_prev = 1'b0;
    logic [9:0] rec_idx[$], rec1_idx[$];
    logic rec_st[$], rec1_st[$];
    logic [15:0] rec_ns[$], rec1_ns[$];
    logic [63:0] starts[$];
    int gaps[$], lows[$];
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (res_valid && res_ready) begin
            rec_idx.push_back(res_idx);
            rec_st.push_back(res_steady);
            rec_ns.push_back(res_state);
            hs_cyc <= cyc;
        end
        if (done) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
        if (seed_rd) n_rd <= n_rd + 1;
        if (dp_rst && !dp_prev) since <= 0;
        else since <= since + 1;
        if (dp_start) begin
            starts.push_back(dp_seed);
            gaps.push_back(since + 1);
        end
        if (!dp_rst) low <= low + 1;
        else if (!dp_prev) begin
            lows.push_back(low);
            low <= 0;
        end
        if ((dp_ld && ld_prev) || (dp_start && st_prev) || (seed_rd && rd_prev) || (done && dn_prev)) multi <= multi + 1;
        if (dp_sel !== 4'hF || dp_sel1 !== 4'hF) sel_bad <= sel_bad + 1;
        dp_prev <= dp_rst;
        ld_prev <= dp_ld;
        st_prev <= dp_start;
        rd_prev <= seed_rd;
        dn_prev <= done;
        if (res_valid1 && res_ready1) begin
            rec1_idx.push_back(res_idx1);
            rec1_st.push_back(res_steady1);
            rec1_ns.push_back(res_state1);
            hs1_cyc <= cyc;
        end
        if (done1) begin
            n_done1   <= n_done1 + 1;
            done1_cyc <= cyc;
        end
    end

    int checks = 0, failures = 0;
    int k, base, d0, s0, l0, g0, rd0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // expected record for seed i: datapath outputs at the moment the round count reaches R
    function automatic logic [15:0] exp_state(input int i);
        return ram[i][15:0] ^ 16'(R);
    endfunction
    function automatic logic exp_steady(input int i);
        return ram[i][16] ^ 1'(R % 2);
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = {32'($urandom), 32'($urandom)};
        ram[1] = {32'($urandom), 15'($urandom), 17'h000F6};
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dp_rst", 64'(dp_rst), 64'd0);
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_dp_seed", dp_seed, 64'd0);
        chk("rst_res_idx", 64'(res_idx), 64'd0);
        chk("rst_res_state", 64'(res_state), 64'd0);
        chk("rst_res_steady", 64'(res_steady), 64'd0);
        chk("rst_seed_rd", 64'(seed_rd), 64'd0);
        chk("rst_start", 64'(dp_start), 64'd0);
        chk("rst_ld", 64'(dp_ld), 64'd0);
        chk("rst_sel", 64'(dp_sel), 64'hF);
        rst = 1'b0;
        tick();
        chk("idle_busy", 64'(busy), 64'd0);

        // full run with a stalled record on seed 1 and ignored go pulses
        base = rec_idx.size(); d0 = n_done; s0 = starts.size(); l0 = lows.size(); g0 = gaps.size();
        go = 1'b1; res_ready = 1'b1;
        tick();
        go = 1'b0;
        chk("go_busy", 64'(busy), 64'd1);
        chk("go_seed_rd", 64'(seed_rd), 64'd1);
        chk("go_seed_addr", 64'(seed_addr), 64'd0);
        k = 0;
        while (!dp_start && k < 50) begin tick(); k++; end
        chk("go_to_start", 64'(k), 64'd7);
        k = 0;
        while (!(seed_rd && seed_addr == 10'd1) && k < 200) begin tick(); k++; end
        chk("wait_fetch1", 64'(seed_rd), 64'd1);
        res_ready = 1'b0;
        k = 0;
        while (!dp_start && k < 50) begin tick(); k++; end
        chk("wait_start1", 64'(dp_start), 64'd1);
        repeat (2) tick();
        go = 1'b1;
        tick();
        go = 1'b0;
        k = 0;
        while (!res_valid && k < 50) begin tick(); k++; end
        chk("stall_valid_rise", 64'(res_valid), 64'd1);
        chk("stall_state0", 64'(res_state), 64'h00F3);
        chk("stall_steady0", 64'(res_steady), 64'd1);
        rd0 = n_rd;
        go = 1'b1;
        repeat (10) begin tick(); go = 1'b0; end
        chk("stall_valid", 64'(res_valid), 64'd1);
        chk("stall_state", 64'(res_state), 64'h00F3);
        chk("stall_steady", 64'(res_steady), 64'd1);
        chk("stall_idx", 64'(res_idx), 64'd1);
        chk("stall_no_fetch", 64'(n_rd - rd0), 64'd0);
        chk("stall_busy", 64'(busy), 64'd1);
        k = 0;
        while (!done && k < 500) begin res_ready = 1'($urandom_range(0, 1)); tick(); k++; end
        chk("run1_done", 64'(done), 64'd1);
        chk("run1_busy_in_done", 64'(busy), 64'd1);
        tick();
        chk("run1_busy_after", 64'(busy), 64'd0);
        chk("run1_done_pulse", 64'(done), 64'd0);
        chk("run1_rec_count", 64'(rec_idx.size() - base), 64'(N));
        for (int i = 0; i < N; i++) begin
            chk($sformatf("run1_idx%0d", i), 64'(rec_idx[base + i]), 64'(i));
            chk($sformatf("run1_steady%0d", i), 64'(rec_st[base + i]), 64'(exp_steady(i)));
            chk($sformatf("run1_state%0d", i), 64'(rec_ns[base + i]), 64'(exp_state(i)));
            chk($sformatf("run1_seed%0d", i), starts[s0 + i], ram[i]);
            chk($sformatf("run1_rls_to_start%0d", i), 64'(gaps[g0 + i]), 64'd3);
        end
        chk("run1_hold_len1", 64'(lows[l0 + 1]), 64'd2);
        chk("run1_hold_len2", 64'(lows[l0 + 2]), 64'd2);
        chk("run1_done_count", 64'(n_done - d0), 64'd1);
        chk("run1_done_after_hs", 64'(done_cyc - hs_cyc), 64'd1);
        chk("run1_dp_rst_held", 64'(dp_rst), 64'd1);

        // reset in the middle of seed 1
        go = 1'b1; res_ready = 1'b1;
        tick();
        go = 1'b0;
        k = 0;
        while (!(seed_rd && seed_addr == 10'd1) && k < 200) begin tick(); k++; end
        k = 0;
        while (!dp_start && k < 50) begin tick(); k++; end
        chk("abort_reach_start1", 64'(dp_seed), ram[1]);
        repeat (2) tick();
        base = rec_idx.size(); d0 = n_done;
        rst = 1'b1;
        tick();
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_dp_rst", 64'(dp_rst), 64'd0);
        chk("abort_valid", 64'(res_valid), 64'd0);
        chk("abort_dp_seed", dp_seed, 64'd0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (20) tick();
        chk("abort_no_rec", 64'(rec_idx.size() - base), 64'd0);
        chk("abort_no_done", 64'(n_done - d0), 64'd0);
        chk("abort_idle_busy", 64'(busy), 64'd0);
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("restart_seed_rd", 64'(seed_rd), 64'd1);
        chk("restart_addr", 64'(seed_addr), 64'd0);
        k = 0;
        while (!done && k < 500) begin res_ready = 1'($urandom_range(0, 1)); tick(); k++; end
        chk("restart_done", 64'(done), 64'd1);
        tick();
        chk("restart_rec_count", 64'(rec_idx.size() - base), 64'(N));
        for (int i = 0; i < N; i++) begin
            chk($sformatf("restart_idx%0d", i), 64'(rec_idx[base + i]), 64'(i));
            chk($sformatf("restart_state%0d", i), 64'(rec_ns[base + i]), 64'(exp_state(i)));
        end
        chk("no_multi_cycle_strobes", 64'(multi), 64'd0);
        chk("sel_all_ones", 64'(sel_bad), 64'd0);

        // single-seed configuration
        go1 = 1'b1; res_ready1 = 1'b1;
        tick();
        go1 = 1'b0;
        chk("one_busy", 64'(busy1), 64'd1);
        k = 0;
        while (!done1 && k < 200) begin tick(); k++; end
        chk("one_done", 64'(done1), 64'd1);
        tick();
        chk("one_busy_after", 64'(busy1), 64'd0);
        chk("one_rec_count", 64'(rec1_idx.size()), 64'd1);
        chk("one_idx", 64'(rec1_idx[0]), 64'd0);
        chk("one_steady", 64'(rec1_st[0]), 64'(exp_steady(0)));
        chk("one_state", 64'(rec1_ns[0]), 64'(exp_state(0)));
        chk("one_done_after_hs", 64'(done1_cyc - hs1_cyc), 64'd1);
        chk("one_done_count", 64'(n_done1), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
